// File: rtl/gpi_ctrl_pkg.sv
// Shared types and constants for the GPI pad controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpi_ctrl_pkg;

    // Receiver sequencing: pad off, IE asserted and settling, sampling live.
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam logic [1:0] IRQ_MODE_OFF  = 2'b00;
    localparam logic [1:0] IRQ_MODE_RISE = 2'b01;
    localparam logic [1:0] IRQ_MODE_FALL = 2'b10;
    localparam logic [1:0] IRQ_MODE_BOTH = 2'b11;

    // True when a debounced edge pulse is enabled by the interrupt mode.
    function automatic logic edge_irq_en(input logic [1:0] mode,
                                         input logic       rise,
                                         input logic       fall);
        logic hit;
        hit = 1'b0;
        if (mode != IRQ_MODE_OFF) begin
            hit = (rise && (mode == IRQ_MODE_RISE || mode == IRQ_MODE_BOTH)) ||
                  (fall && (mode == IRQ_MODE_FALL || mode == IRQ_MODE_BOTH));
        end
        return hit;
    endfunction

endpackage

// File: rtl/gpi_pad_ctrl_if.sv
// Signal bundle between the GPIO register block / pad ring and gpi_pad_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or single-cycle pulse.
// Ports: EN_I, STE_CFG_I, DEB_CNT_I, IRQ_MODE_I, IRQ_ACK_I, PAD_DI_I into the
//        controller; PAD_IE_O, PAD_STE_O, VALID_O, LEVEL_O, RISE_O, FALL_O,
//        IRQ_O, MISMATCH_O out of it. slave = controller view, master = driver view.
interface gpi_pad_ctrl_if #(
    parameter int DEB_W = 8
);
    logic             EN_I;
    logic [1:0]       STE_CFG_I;
    logic [DEB_W-1:0] DEB_CNT_I;
    logic [1:0]       IRQ_MODE_I;
    logic             IRQ_ACK_I;
    logic [1:0]       PAD_DI_I;
    logic             PAD_IE_O;
    logic [1:0]       PAD_STE_O;
    logic             VALID_O;
    logic             LEVEL_O;
    logic             RISE_O;
    logic             FALL_O;
    logic             IRQ_O;
    logic             MISMATCH_O;

    modport slave (
        input  EN_I, STE_CFG_I, DEB_CNT_I, IRQ_MODE_I, IRQ_ACK_I, PAD_DI_I,
        output PAD_IE_O, PAD_STE_O, VALID_O, LEVEL_O, RISE_O, FALL_O,
               IRQ_O, MISMATCH_O
    );

    modport master (
        output EN_I, STE_CFG_I, DEB_CNT_I, IRQ_MODE_I, IRQ_ACK_I, PAD_DI_I,
        input  PAD_IE_O, PAD_STE_O, VALID_O, LEVEL_O, RISE_O, FALL_O,
               IRQ_O, MISMATCH_O
    );
endinterface

// File: rtl/gpi_sync2.sv
// Two-flop synchroniser for one asynchronous pad rail.
// Latency: 2 clk_i edges from d_i to q_o.
// Backpressure: none; samples every cycle.
// Ports: clk_i, rst_ni (async active-low), d_i (async in), q_o (synchronised out).
module gpi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/gpi_pad_ctrl.sv
// Core-side controller for one GPI pull-up pad: IE sequencing, sync, debounce, edges, IRQ.
// Latency: pad change -> LEVEL_O in 3+DEB_CNT_I cycles; edge -> IRQ_O one cycle later.
// Backpressure: none; pad is sampled every cycle, IRQ_O holds until acknowledged.
// Ports: CLK_I, RSTN_I (async active-low) plain; everything else via pad_if (slave).
module gpi_pad_ctrl
    import gpi_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int DEB_W      = 8
) (
    input logic           CLK_I,
    input logic           RSTN_I,
    gpi_pad_ctrl_if.slave pad_if
);
    localparam int TMR_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ste_q, ste_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             irq_q, irq_d;
    logic             diff_q, diff_d;
    logic             mism_q, mism_d;
    logic             s0, s1;

    // Both rails reset to 1 so the pull-up idle level never looks like an edge.
    gpi_sync2 #(.RST_VAL(1'b1)) u_sync_r0 (
        .clk_i (CLK_I),
        .rst_ni(RSTN_I),
        .d_i   (pad_if.PAD_DI_I[0]),
        .q_o   (s0)
    );

    gpi_sync2 #(.RST_VAL(1'b1)) u_sync_r1 (
        .clk_i (CLK_I),
        .rst_ni(RSTN_I),
        .d_i   (pad_if.PAD_DI_I[1]),
        .q_o   (s1)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        ste_d   = ste_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        diff_d  = diff_q;
        mism_d  = mism_q;
        // A new set beats a coincident ack; mode 00 only masks new sets.
        irq_d   = edge_irq_en(pad_if.IRQ_MODE_I, rise_q, fall_q) ||
                  (irq_q && !pad_if.IRQ_ACK_I);

        unique case (state_q)
            OFF: begin
                tmr_d  = '0;
                cnt_d  = '0;
                diff_d = 1'b0;
                mism_d = 1'b0;
                if (pad_if.EN_I) begin
                    state_d = SETTLE;
                    ste_d   = pad_if.STE_CFG_I;
                end
            end
            SETTLE: begin
                if (!pad_if.EN_I) begin
                    state_d = OFF;
                end else if (tmr_q == TMR_LAST) begin
                    // First valid sample seeds LEVEL_O directly, without an edge.
                    state_d = ACTIVE;
                    level_d = s0;
                    cnt_d   = '0;
                    diff_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (!pad_if.EN_I) begin
                    state_d = OFF;
                    cnt_d   = '0;
                    diff_d  = 1'b0;
                    mism_d  = 1'b0;
                end else begin
                    if (s0 != level_q) begin
                        // Compare the pre-increment count so a glitch needs
                        // DEB_CNT_I+1 consecutive samples to get through.
                        if (cnt_q >= pad_if.DEB_CNT_I) begin
                            level_d = s0;
                            cnt_d   = '0;
                            rise_d  = s0;
                            fall_d  = !s0;
                        end else if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                    // Rails must disagree on two consecutive samples to flag.
                    diff_d = s0 ^ s1;
                    if (diff_q && (s0 ^ s1)) begin
                        mism_d = 1'b1;
                    end
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= OFF;
            tmr_q   <= '0;
            cnt_q   <= '0;
            ste_q   <= 2'b00;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            irq_q   <= 1'b0;
            diff_q  <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ste_q   <= ste_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            diff_q  <= diff_d;
            mism_q  <= mism_d;
        end
    end

    // Decoded from the state flop so reset drops IE without waiting for a clock.
    assign pad_if.PAD_IE_O   = (state_q != OFF);
    assign pad_if.VALID_O    = (state_q == ACTIVE);
    assign pad_if.PAD_STE_O  = ste_q;
    assign pad_if.LEVEL_O    = level_q;
    assign pad_if.RISE_O     = rise_q;
    assign pad_if.FALL_O     = fall_q;
    assign pad_if.IRQ_O      = irq_q;
    assign pad_if.MISMATCH_O = mism_q;
endmodule

// File: tb/tb_gpi_pad_ctrl.sv
module tb_gpi_pad_ctrl;
    typedef struct {
        logic is_rise;
        int   cyc;
    } edge_ev_t;

    logic clk;
    logic rstn;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    edge_ev_t exp_q[$];
    edge_ev_t mon_ev;

    gpi_pad_ctrl_if #(.DEB_W(8)) bus ();

    gpi_pad_ctrl #(.SETTLE_CYC(16), .DEB_W(8)) dut (
        .CLK_I (clk),
        .RSTN_I(rstn),
        .pad_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every RISE/FALL pulse must match the next expected edge and cycle.
    always @(posedge clk) begin
        #1;
        if (bus.RISE_O || bus.FALL_O) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL edge_unexpected: got rise=%0b fall=%0b at cyc %0d, required no edge",
                         bus.RISE_O, bus.FALL_O, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                if (bus.RISE_O !== mon_ev.is_rise || bus.FALL_O !== !mon_ev.is_rise ||
                    cyc != mon_ev.cyc) begin
                    errors++;
                    $display("FAIL edge_match: got rise=%0b fall=%0b cyc=%0d, required rise=%0b cyc=%0d",
                             bus.RISE_O, bus.FALL_O, cyc, mon_ev.is_rise, mon_ev.cyc);
                end
            end
        end
    end

    task automatic test_reset;
        logic [8:0] got;
        rstn = 1'b0;
        bus.EN_I = 1'b0; bus.STE_CFG_I = 2'b10; bus.DEB_CNT_I = 8'd4;
        bus.IRQ_MODE_I = 2'b00; bus.IRQ_ACK_I = 1'b0; bus.PAD_DI_I = 2'b11;
        tick(3);
        got = {bus.PAD_IE_O, bus.PAD_STE_O, bus.VALID_O, bus.LEVEL_O,
               bus.RISE_O, bus.FALL_O, bus.IRQ_O, bus.MISMATCH_O};
        checks++;
        if (got !== 9'b0_00_0_1_0_0_0_0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required %b", got, 9'b0_00_0_1_0_0_0_0);
        end
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic test_settle;
        int n;
        bus.STE_CFG_I = 2'b10;
        bus.EN_I = 1'b1;
        tick(1);
        checks++;
        if (bus.PAD_IE_O !== 1'b1 || bus.PAD_STE_O !== 2'b10) begin
            errors++;
            $display("FAIL settle_ie: got ie=%b ste=%b, required ie=1 ste=10", bus.PAD_IE_O, bus.PAD_STE_O);
        end
        bus.STE_CFG_I = 2'b01;
        n = 0;
        while (bus.VALID_O !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL settle_len: got %0d cycles IE->VALID, required 16", n);
        end
        checks++;
        if (bus.PAD_STE_O !== 2'b10 || bus.LEVEL_O !== 1'b1) begin
            errors++;
            $display("FAIL settle_ste_hold: got ste=%b level=%b, required ste=10 level=1",
                     bus.PAD_STE_O, bus.LEVEL_O);
        end
    endtask

    task automatic test_fall_debounce;
        int c;
        bus.IRQ_MODE_I = 2'b10;
        bus.DEB_CNT_I = 8'd4;
        c = cyc;
        bus.PAD_DI_I = 2'b00;
        exp_q.push_back('{1'b0, c + 7});
        tick(6);
        checks++;
        if (bus.LEVEL_O !== 1'b1) begin
            errors++;
            $display("FAIL fall_early: got level=%b at +6, required 1", bus.LEVEL_O);
        end
        tick(1);
        checks++;
        if (bus.LEVEL_O !== 1'b0 || bus.IRQ_O !== 1'b0) begin
            errors++;
            $display("FAIL fall_level: got level=%b irq=%b at +7, required level=0 irq=0",
                     bus.LEVEL_O, bus.IRQ_O);
        end
        tick(1);
        checks++;
        if (bus.IRQ_O !== 1'b1) begin
            errors++;
            $display("FAIL fall_irq: got irq=%b at +8, required 1", bus.IRQ_O);
        end
        bus.IRQ_ACK_I = 1'b1;
        tick(1);
        bus.IRQ_ACK_I = 1'b0;
        checks++;
        if (bus.IRQ_O !== 1'b0) begin
            errors++;
            $display("FAIL fall_ack: got irq=%b after ack, required 0", bus.IRQ_O);
        end
    endtask

    task automatic test_glitch;
        int c;
        int glen [2] = '{3, 4};
        c = cyc;
        bus.PAD_DI_I = 2'b11;
        exp_q.push_back('{1'b1, c + 7});
        tick(9);
        checks++;
        if (bus.LEVEL_O !== 1'b1 || bus.IRQ_O !== 1'b0) begin
            errors++;
            $display("FAIL rise_masked: got level=%b irq=%b, required level=1 irq=0",
                     bus.LEVEL_O, bus.IRQ_O);
        end
        foreach (glen[i]) begin
            bus.PAD_DI_I = 2'b00;
            tick(glen[i]);
            bus.PAD_DI_I = 2'b11;
            tick(10);
            checks++;
            if (bus.LEVEL_O !== 1'b1 || dut.cnt_q !== 8'd0) begin
                errors++;
                $display("FAIL glitch_%0d: got level=%b cnt=%0d, required level=1 cnt=0",
                         glen[i], bus.LEVEL_O, dut.cnt_q);
            end
        end
        c = cyc;
        bus.PAD_DI_I = 2'b00;
        exp_q.push_back('{1'b0, c + 7});
        tick(5);
        bus.PAD_DI_I = 2'b11;
        exp_q.push_back('{1'b1, c + 12});
        tick(14);
        checks++;
        if (bus.LEVEL_O !== 1'b1 || bus.IRQ_O !== 1'b1) begin
            errors++;
            $display("FAIL glitch_5: got level=%b irq=%b, required level=1 irq=1",
                     bus.LEVEL_O, bus.IRQ_O);
        end
    endtask

    task automatic test_deb_change;
        int c;
        bus.DEB_CNT_I = 8'd200;
        c = cyc;
        bus.PAD_DI_I = 2'b00;
        exp_q.push_back('{1'b0, c + 6});
        tick(5);
        bus.DEB_CNT_I = 8'd2;
        tick(1);
        checks++;
        if (bus.LEVEL_O !== 1'b0) begin
            errors++;
            $display("FAIL deb_lowered: got level=%b, required 0", bus.LEVEL_O);
        end
        bus.DEB_CNT_I = 8'd0;
        c = cyc;
        bus.PAD_DI_I = 2'b11;
        exp_q.push_back('{1'b1, c + 3});
        tick(2);
        checks++;
        if (bus.LEVEL_O !== 1'b0) begin
            errors++;
            $display("FAIL deb0_early: got level=%b at +2, required 0", bus.LEVEL_O);
        end
        tick(1);
        checks++;
        if (bus.LEVEL_O !== 1'b1) begin
            errors++;
            $display("FAIL deb0_level: got level=%b at +3, required 1", bus.LEVEL_O);
        end
        bus.DEB_CNT_I = 8'd4;
        tick(2);
    endtask

    task automatic test_irq_collision;
        int c;
        bus.IRQ_MODE_I = 2'b00;
        c = cyc;
        bus.PAD_DI_I = 2'b00;
        exp_q.push_back('{1'b0, c + 7});
        tick(9);
        checks++;
        if (bus.IRQ_O !== 1'b1 || bus.LEVEL_O !== 1'b0) begin
            errors++;
            $display("FAIL irq_mode00_hold: got irq=%b level=%b, required irq=1 level=0",
                     bus.IRQ_O, bus.LEVEL_O);
        end
        bus.IRQ_MODE_I = 2'b11;
        c = cyc;
        bus.PAD_DI_I = 2'b11;
        exp_q.push_back('{1'b1, c + 7});
        tick(7);
        bus.IRQ_ACK_I = 1'b1;
        tick(1);
        bus.IRQ_ACK_I = 1'b0;
        checks++;
        if (bus.IRQ_O !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: got irq=%b, required 1", bus.IRQ_O);
        end
        bus.IRQ_ACK_I = 1'b1;
        tick(1);
        bus.IRQ_ACK_I = 1'b0;
        checks++;
        if (bus.IRQ_O !== 1'b0) begin
            errors++;
            $display("FAIL irq_second_ack: got irq=%b, required 0", bus.IRQ_O);
        end
    endtask

    task automatic test_mismatch;
        bus.PAD_DI_I = 2'b01;
        tick(3);
        checks++;
        if (bus.MISMATCH_O !== 1'b0) begin
            errors++;
            $display("FAIL mism_early: got %b at +3, required 0", bus.MISMATCH_O);
        end
        tick(1);
        checks++;
        if (bus.MISMATCH_O !== 1'b1) begin
            errors++;
            $display("FAIL mism_set: got %b at +4, required 1", bus.MISMATCH_O);
        end
        bus.PAD_DI_I = 2'b11;
        tick(4);
        checks++;
        if (bus.MISMATCH_O !== 1'b1) begin
            errors++;
            $display("FAIL mism_sticky: got %b, required 1", bus.MISMATCH_O);
        end
        bus.EN_I = 1'b0;
        tick(1);
        checks++;
        if (bus.MISMATCH_O !== 1'b0 || bus.PAD_IE_O !== 1'b0 || bus.VALID_O !== 1'b0 ||
            bus.LEVEL_O !== 1'b1) begin
            errors++;
            $display("FAIL mism_off: got mism=%b ie=%b valid=%b level=%b, required 0 0 0 1",
                     bus.MISMATCH_O, bus.PAD_IE_O, bus.VALID_O, bus.LEVEL_O);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        int n;
        logic [8:0] got;
        bus.EN_I = 1'b1;
        tick(5);
        rstn = 1'b0;
        #1;
        got = {bus.PAD_IE_O, bus.PAD_STE_O, bus.VALID_O, bus.LEVEL_O,
               bus.RISE_O, bus.FALL_O, bus.IRQ_O, bus.MISMATCH_O};
        checks++;
        if (got !== 9'b0_00_0_1_0_0_0_0) begin
            errors++;
            $display("FAIL rst_settle: got %b, required %b", got, 9'b0_00_0_1_0_0_0_0);
        end
        tick(2);
        rstn = 1'b1;
        tick(1);
        n = 0;
        while (bus.VALID_O !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL rst_resettle: got %0d cycles, required 16", n);
        end
        c = cyc;
        bus.PAD_DI_I = 2'b00;
        exp_q.push_back('{1'b0, c + 7});
        tick(9);
        bus.DEB_CNT_I = 8'd8;
        bus.PAD_DI_I = 2'b11;
        tick(6);
        checks++;
        if (dut.cnt_q !== 8'd4 || bus.LEVEL_O !== 1'b0 || bus.IRQ_O !== 1'b1) begin
            errors++;
            $display("FAIL rst_precount: got cnt=%0d level=%b irq=%b, required 4 0 1",
                     dut.cnt_q, bus.LEVEL_O, bus.IRQ_O);
        end
        #2;
        rstn = 1'b0;
        #1;
        got = {bus.PAD_IE_O, bus.PAD_STE_O, bus.VALID_O, bus.LEVEL_O,
               bus.RISE_O, bus.FALL_O, bus.IRQ_O, bus.MISMATCH_O};
        checks++;
        if (got !== 9'b0_00_0_1_0_0_0_0 || dut.cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL rst_debounce: got %b cnt=%0d, required %b cnt=0",
                     got, dut.cnt_q, 9'b0_00_0_1_0_0_0_0);
        end
        bus.PAD_DI_I = 2'b00;
        tick(2);
        rstn = 1'b1;
        tick(1);
        n = 0;
        while (bus.VALID_O !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != 16 || bus.LEVEL_O !== 1'b0) begin
            errors++;
            $display("FAIL rst_reload: got %0d cycles level=%b, required 16 level=0", n, bus.LEVEL_O);
        end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_settle();
        test_fall_debounce();
        test_glitch();
        test_deb_change();
        test_irq_collision();
        test_mismatch();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL edges_outstanding: got %0d unseen edges, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
